// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: FSM state encoding, request-type constants and the owner tag
//          used to steer a grant to the fetch or data port.
// Ports:   none (package).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response bus bundle between processor, arbiter and memory
//
// Purpose: groups the fetch port (imem*), data port (dmem*) and memory port (mem*).
// Modports:
//   master - processor/memory environment side (drives requests and memory responses)
//   slave  - arbiter side (drives rdy, per-port responses and the memory request)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imemreq_val;
   logic [ADDR_W-1:0] imemreq_addr;
   logic              imemreq_rdy;
   logic              imemresp_val;
   logic [DATA_W-1:0] imemresp_data;

   logic              dmemreq_val;
   logic              dmemreq_type;
   logic [ADDR_W-1:0] dmemreq_addr;
   logic [DATA_W-1:0] dmemreq_wdata;
   logic              dmemreq_rdy;
   logic              dmemresp_val;
   logic [DATA_W-1:0] dmemresp_rdata;

   logic              memreq_val;
   logic              memreq_type;
   logic [ADDR_W-1:0] memreq_addr;
   logic [DATA_W-1:0] memreq_wdata;
   logic              memreq_rdy;
   logic              memresp_val;
   logic [DATA_W-1:0] memresp_data;

   modport master (
      output imemreq_val, imemreq_addr,
      input  imemreq_rdy, imemresp_val, imemresp_data,
      output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
      input  dmemreq_rdy, dmemresp_val, dmemresp_rdata,
      input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
      output memreq_rdy, memresp_val, memresp_data
   );

   modport slave (
      input  imemreq_val, imemreq_addr,
      output imemreq_rdy, imemresp_val, imemresp_data,
      input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
      output dmemreq_rdy, dmemresp_val, dmemresp_rdata,
      output memreq_val, memreq_type, memreq_addr, memreq_wdata,
      input  memreq_rdy, memresp_val, memresp_data
   );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of dmem grants taken while imem waits
//
// Purpose: only built when ARB_STARVE_GUARD_EN is defined; trip tells the
//          arbiter to let the fetch port win the next grant.
// Ports:
//   clk, rst - clock, asynchronous active-low reset
//   inc      - a dmem request fired while imem was valid
//   clr      - imem fired, or imem idle while the arbiter is in IDLE
//   trip     - count has reached STARVE_MAX
module mem_arb_starve_ctr #(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic trip
);
   localparam int CW = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign trip = (cnt_q == CW'(STARVE_MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
//
// Purpose: one outstanding memory transaction at a time; dmem has priority,
//          the losing port sees rdy = 0; the response is routed to the owner.
//          Optional macro ARB_STARVE_GUARD_EN lets imem win after STARVE_MAX
//          consecutive dmem grants taken while imem was waiting.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave: imem*, dmem* and mem* request/response signals
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [DATA_W-1:0] ZERO_DATA = '0;

   state_e state_q, state_d;
   logic   type_q,  type_d;
   owner_e owner;
   logic   grant_val;
   logic   starve_trip;

`ifdef ARB_STARVE_GUARD_EN
   logic starve_inc;
   logic starve_clr;

   // rdy high means that port fired this cycle.
   assign starve_inc = bus.dmemreq_rdy && bus.imemreq_val;
   assign starve_clr = bus.imemreq_rdy || ((state_q == IDLE) && !bus.imemreq_val);

   mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (starve_inc),
      .clr  (starve_clr),
      .trip (starve_trip)
   );
`else
   // Never true: fixed priority, dmem always wins.
   assign starve_trip = (STARVE_MAX < 0);
`endif

   always_comb begin
      state_d            = state_q;
      type_d             = type_q;
      owner              = OWN_D;
      grant_val          = 1'b0;
      bus.memreq_val     = 1'b0;
      bus.memreq_type    = MEM_READ;
      bus.memreq_addr    = ZERO_ADDR;
      bus.memreq_wdata   = ZERO_DATA;
      bus.imemreq_rdy    = 1'b0;
      bus.dmemreq_rdy    = 1'b0;
      bus.imemresp_val   = 1'b0;
      bus.imemresp_data  = ZERO_DATA;
      bus.dmemresp_val   = 1'b0;
      bus.dmemresp_rdata = ZERO_DATA;

      case (state_q)
         IDLE: begin
            // Winner is recomputed every cycle; nothing is locked before fire.
            if (bus.dmemreq_val && !(starve_trip && bus.imemreq_val)) begin
               grant_val = 1'b1;
               owner     = OWN_D;
            end else if (bus.imemreq_val) begin
               grant_val = 1'b1;
               owner     = OWN_I;
            end
            if (grant_val) begin
               bus.memreq_val = 1'b1;
               if (owner == OWN_D) begin
                  bus.memreq_type  = bus.dmemreq_type;
                  bus.memreq_addr  = bus.dmemreq_addr;
                  bus.memreq_wdata = bus.dmemreq_wdata;
                  bus.dmemreq_rdy  = bus.memreq_rdy;
               end else begin
                  bus.memreq_addr  = bus.imemreq_addr;
                  bus.imemreq_rdy  = bus.memreq_rdy;
               end
               if (bus.memreq_rdy) begin
                  state_d = (owner == OWN_D) ? WAIT_D : WAIT_I;
                  type_d  = (owner == OWN_D) ? bus.dmemreq_type : MEM_READ;
               end
            end
         end
         WAIT_I: begin
            if (bus.memresp_val) begin
               bus.imemresp_val  = 1'b1;
               bus.imemresp_data = bus.memresp_data;
               state_d           = IDLE;
            end
         end
         WAIT_D: begin
            if (bus.memresp_val) begin
               bus.dmemresp_val   = 1'b1;
               bus.dmemresp_rdata = (type_q == MEM_WRITE) ? ZERO_DATA : bus.memresp_data;
               state_d            = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are quiet while reset is held, even if requesters are valid.
      if (!rst) begin
         bus.memreq_val     = 1'b0;
         bus.memreq_type    = MEM_READ;
         bus.memreq_addr    = ZERO_ADDR;
         bus.memreq_wdata   = ZERO_DATA;
         bus.imemreq_rdy    = 1'b0;
         bus.dmemreq_rdy    = 1'b0;
         bus.imemresp_val   = 1'b0;
         bus.imemresp_data  = ZERO_DATA;
         bus.dmemresp_val   = 1'b0;
         bus.dmemresp_rdata = ZERO_DATA;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         type_q  <= MEM_READ;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      bus.imemreq_val   = 1'b0;
      bus.imemreq_addr  = '0;
      bus.dmemreq_val   = 1'b0;
      bus.dmemreq_type  = MEM_READ;
      bus.dmemreq_addr  = '0;
      bus.dmemreq_wdata = '0;
      bus.memresp_val   = 1'b0;
      bus.memresp_data  = '0;
   endtask

   initial begin
      logic exp_i;
      checks   = 0;
      failures = 0;
      idle_inputs();
      bus.memreq_rdy = 1'b1;
      rst = 1'b0;

      // Reset: a valid fetch must not be accepted while reset is held.
      #1;
      bus.imemreq_val  = 1'b1;
      bus.imemreq_addr = 32'h200;
      sample();
      chk("rst_imemreq_rdy", {31'd0, bus.imemreq_rdy}, 32'd0);
      chk("rst_dmemreq_rdy", {31'd0, bus.dmemreq_rdy}, 32'd0);
      chk("rst_memreq_val", {31'd0, bus.memreq_val}, 32'd0);
      chk("rst_imemresp_val", {31'd0, bus.imemresp_val}, 32'd0);
      chk("rst_dmemresp_val", {31'd0, bus.dmemresp_val}, 32'd0);
      chk("rst_memreq_addr", bus.memreq_addr, 32'd0);
      next_cycle();
      rst = 1'b1;

      // Single fetch, L = 1.
      sample();
      chk("fetch_imemreq_rdy", {31'd0, bus.imemreq_rdy}, 32'd1);
      chk("fetch_memreq_val", {31'd0, bus.memreq_val}, 32'd1);
      chk("fetch_memreq_addr", bus.memreq_addr, 32'h200);
      chk("fetch_memreq_type", {31'd0, bus.memreq_type}, 32'd0);
      next_cycle();
      bus.imemreq_val  = 1'b0;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h00A00093;
      sample();
      chk("fetch_imemresp_val", {31'd0, bus.imemresp_val}, 32'd1);
      chk("fetch_imemresp_data", bus.imemresp_data, 32'h00A00093);
      chk("fetch_dmemresp_val", {31'd0, bus.dmemresp_val}, 32'd0);
      chk("fetch_wait_memreq_val", {31'd0, bus.memreq_val}, 32'd0);
      next_cycle();
      idle_inputs();

      // Conflict: dmem wins, imem fires two cycles later.
      bus.imemreq_val  = 1'b1;
      bus.imemreq_addr = 32'h204;
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_type = MEM_READ;
      bus.dmemreq_addr = 32'h1000;
      sample();
      chk("conf_dmemreq_rdy", {31'd0, bus.dmemreq_rdy}, 32'd1);
      chk("conf_imemreq_rdy", {31'd0, bus.imemreq_rdy}, 32'd0);
      chk("conf_memreq_addr", bus.memreq_addr, 32'h1000);
      next_cycle();
      bus.dmemreq_val  = 1'b0;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'hDEADBEEF;
      sample();
      chk("conf_dmemresp_val", {31'd0, bus.dmemresp_val}, 32'd1);
      chk("conf_dmemresp_rdata", bus.dmemresp_rdata, 32'hDEADBEEF);
      chk("conf_resp_imemreq_rdy", {31'd0, bus.imemreq_rdy}, 32'd0);
      next_cycle();
      bus.memresp_val = 1'b0;
      sample();
      chk("conf_imem_fire", {31'd0, bus.imemreq_rdy}, 32'd1);
      chk("conf_imem_addr", bus.memreq_addr, 32'h204);
      next_cycle();
      bus.imemreq_val  = 1'b0;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h11111111;
      sample();
      chk("conf_imemresp_data", bus.imemresp_data, 32'h11111111);
      next_cycle();
      idle_inputs();

      // Write ack returns rdata 0.
      bus.dmemreq_val   = 1'b1;
      bus.dmemreq_type  = MEM_WRITE;
      bus.dmemreq_addr  = 32'h1004;
      bus.dmemreq_wdata = 32'h12345678;
      sample();
      chk("wr_memreq_type", {31'd0, bus.memreq_type}, 32'd1);
      chk("wr_memreq_wdata", bus.memreq_wdata, 32'h12345678);
      chk("wr_memreq_addr", bus.memreq_addr, 32'h1004);
      next_cycle();
      bus.dmemreq_val  = 1'b0;
      bus.dmemreq_type = MEM_READ;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'hCAFEF00D;
      sample();
      chk("wr_dmemresp_val", {31'd0, bus.dmemresp_val}, 32'd1);
      chk("wr_dmemresp_rdata", bus.dmemresp_rdata, 32'd0);
      next_cycle();
      idle_inputs();

      // Back-pressure for 3 cycles (with a spurious response), fire on the 4th.
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_addr = 32'h2000;
      bus.memreq_rdy   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.memresp_val  = (c == 1);
         bus.memresp_data = 32'h99999999;
         sample();
         chk($sformatf("bp%0d_dmemreq_rdy", c), {31'd0, bus.dmemreq_rdy}, 32'd0);
         chk($sformatf("bp%0d_memreq_val", c), {31'd0, bus.memreq_val}, 32'd1);
         chk($sformatf("bp%0d_dmemresp_val", c), {31'd0, bus.dmemresp_val}, 32'd0);
         next_cycle();
      end
      bus.memresp_val = 1'b0;
      bus.memreq_rdy  = 1'b1;
      sample();
      chk("bp_fire_dmemreq_rdy", {31'd0, bus.dmemreq_rdy}, 32'd1);
      next_cycle();
      bus.dmemreq_val  = 1'b0;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h55AA55AA;
      sample();
      chk("bp_dmemresp_rdata", bus.dmemresp_rdata, 32'h55AA55AA);
      next_cycle();
      idle_inputs();

      // Starvation: both continuously valid; guard gives grant 4 to imem.
      for (int k = 0; k < 4; k++) begin
         exp_i = GUARD && (k == 3);
         bus.imemreq_val  = 1'b1;
         bus.imemreq_addr = 32'h300;
         bus.dmemreq_val  = 1'b1;
         bus.dmemreq_addr = 32'h3000;
         bus.memresp_val  = 1'b0;
         sample();
         chk($sformatf("starve%0d_imemreq_rdy", k), {31'd0, bus.imemreq_rdy}, {31'd0, exp_i});
         chk($sformatf("starve%0d_dmemreq_rdy", k), {31'd0, bus.dmemreq_rdy}, {31'd0, !exp_i});
         next_cycle();
         bus.memresp_val  = 1'b1;
         bus.memresp_data = 32'hA0 + k;
         sample();
         chk($sformatf("starve%0d_imemresp_val", k), {31'd0, bus.imemresp_val}, {31'd0, exp_i});
         chk($sformatf("starve%0d_dmemresp_val", k), {31'd0, bus.dmemresp_val}, {31'd0, !exp_i});
         next_cycle();
      end
      idle_inputs();

      // Reset while in WAIT_D; the late response must be dropped.
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_addr = 32'h4000;
      sample();
      chk("rstw_dmemreq_rdy", {31'd0, bus.dmemreq_rdy}, 32'd1);
      next_cycle();
      bus.dmemreq_val = 1'b0;
      rst = 1'b0;
      sample();
      chk("rstw_dmemresp_val_in_rst", {31'd0, bus.dmemresp_val}, 32'd0);
      next_cycle();
      rst = 1'b1;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h77777777;
      sample();
      chk("rstw_late_dmemresp_val", {31'd0, bus.dmemresp_val}, 32'd0);
      chk("rstw_late_imemresp_val", {31'd0, bus.imemresp_val}, 32'd0);
      next_cycle();
      bus.memresp_val  = 1'b0;
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_addr = 32'h4004;
      sample();
      chk("rstw_next_dmemreq_rdy", {31'd0, bus.dmemreq_rdy}, 32'd1);
      chk("rstw_next_memreq_addr", bus.memreq_addr, 32'h4004);
      next_cycle();
      bus.dmemreq_val  = 1'b0;
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h88888888;
      sample();
      chk("rstw_next_dmemresp_rdata", bus.dmemresp_rdata, 32'h88888888);
      next_cycle();
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported memory between the processor's instruction fetch port and its data port.
- Sits between the TinyRV1 pipelined processor and the unified memory.
- Grants at most one outstanding request at a time and returns each response to its owner.
- Back-pressures the losing port through its ready signal; the processor treats `!rdy` as a stall.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 3, consecutive dmem grants tolerated while imem waits (guard only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imemreq_val  in  1  fetch request valid
- imemreq_addr  in  ADDR_W  fetch address
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemresp_val  out  1  fetch response valid
- imemresp_data  out  DATA_W  fetched instruction
- dmemreq_val  in  1  data request valid
- dmemreq_type  in  1  0 = read, 1 = write
- dmemreq_addr  in  ADDR_W  data address
- dmemreq_wdata  in  DATA_W  store data
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemresp_val  out  1  data response valid (read data or write ack)
- dmemresp_rdata  out  DATA_W  load data; 0 on write ack
- memreq_val  out  1  memory request valid
- memreq_type  out  1  0 = read, 1 = write
- memreq_addr  out  ADDR_W  memory address
- memreq_wdata  out  DATA_W  memory store data
- memreq_rdy  in  1  memory accepts request
- memresp_val  in  1  memory response valid (reads and writes)
- memresp_data  in  DATA_W  memory read data

## Operation
- States: IDLE, WAIT_I, WAIT_D.
- **IDLE:**
  - Select a winner among valid requesters and drive its fields onto memreq_*.
  - memreq_val = winner exists.
  - Winner's rdy = memreq_rdy; loser's rdy = 0.
  - On fire (memreq_val && memreq_rdy), go to WAIT_I or WAIT_D.
- **Priority:** dmem beats imem, because dmem is the older instruction in M.
- **WAIT_x:**
  - memreq_val = 0; both rdy = 0.
  - On memresp_val: assert x's resp_val for that cycle with memresp_data, then return to IDLE.
  - dmem write ack returns rdata = 0.
  - The response type is the type latched at fire.
- **memresp_val in IDLE:** spurious; ignored, no resp_val asserted.
- **Request stability:** requesters hold val/addr/wdata stable until their rdy; the arbiter does not latch unaccepted requests.
- **Simultaneous events:** both valid in IDLE with guard not tripped → dmem wins; imem sees rdy = 0.
- **memreq_rdy = 0 in IDLE:** grant is recomputed every cycle; no lock-in before fire.
- **Reset (rst = 0) at any time:**
  - State → IDLE, counter → 0.
  - Outstanding transaction abandoned; its late response is ignored as spurious.

## Timing
- Reset values: all *_rdy = 0, memreq_val = 0, imemresp_val = 0, dmemresp_val = 0, data outputs 0.
- Request path is combinational: fire in cycle N.
- Response for a memory of latency L appears on *resp_val in cycle N+L, combinationally from memresp_*.
- Next grant earliest N+L+1, so peak throughput is one request per L+1 cycles.
- Grant and response never occur in the same cycle.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A counter (width ≥ clog2(STARVE_MAX+1)) increments on each dmem fire while imemreq_val = 1.
  - It clears on any imem fire, or when imemreq_val = 0 in IDLE.
  - While counter == STARVE_MAX, imem beats dmem in IDLE.
- Undefined: pure fixed priority (dmem always wins); counter logic absent.

## Structure
- Package `mem_arb_pkg`:
  - State enum {IDLE, WAIT_I, WAIT_D}.
  - Constants MEM_READ = 1'b0, MEM_WRITE = 1'b1.
  - Owner enum {OWN_I, OWN_D}.
- Sub-module `mem_arb_starve_ctr`:
  - Saturating starvation counter with inputs inc, clr; output trip.
  - Instantiated only under `ARB_STARVE_GUARD_EN`.
- Top-level module: FSM and muxing.

## Test plan
- **Single fetch:** imem val, addr 0x200; memory L = 1, data 0x00A00093 → imemreq_rdy in cycle 0; imemresp_val, data 0x00A00093 in cycle 1; dmemresp_val stays 0.
- **Conflict:** imem 0x204 and dmem read 0x1000 valid together → dmem fires first; dmemresp_rdata = 0xDEADBEEF; imem fires 2 cycles later.
- **Write ack:** dmem write 0x1004 with 0x12345678 → memreq_type = 1, wdata 0x12345678; dmemresp_val with rdata 0.
- **Back-pressure:** memreq_rdy = 0 for 3 cycles → rdy stays low and no state change; fire on the 4th cycle.
- **Starvation (guard on):** dmem continuously valid plus imem valid → exactly 3 dmem grants, then one imem grant. With the guard off, imem never granted.
- **Reset mid-WAIT_D:** rst low for 1 cycle, then late memresp_val → no dmemresp_val; state IDLE; next request granted normally.
